// File: rtl/serial_chunk_adder.sv
// rtl/serial_chunk_adder.sv - digit-serial WIDTH-bit adder with valid/ready handshakes
// Optional signed-overflow output enabled by defining SCA_OVERFLOW_EN.
module serial_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SCA_OVERFLOW_EN
  , output logic           overflow
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH % DIGIT != 0) begin : g_bad_width
      $error("serial_chunk_adder: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             c_out_q;
  logic             last;
  logic [DIGIT-1:0] slice_a, slice_b;
  logic [DIGIT:0]   slice_sum;

  // The only adder in the block: one DIGIT-bit slice plus the running carry.
  assign slice_a   = a_q[cnt*DIGIT +: DIGIT];
  assign slice_b   = b_q[cnt*DIGIT +: DIGIT];
  assign slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{DIGIT{1'b0}}, carry};
  assign last      = (cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      c_out_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= in1;
            b_q   <= in2;
            carry <= c_in;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum_q[cnt*DIGIT +: DIGIT] <= slice_sum[DIGIT-1:0];
          carry <= slice_sum[DIGIT];
          cnt   <= cnt + CW'(1);
          if (last) c_out_q <= slice_sum[DIGIT];
        end
        default: ;
      endcase
    end
  end

`ifdef SCA_OVERFLOW_EN
  logic ovf_q;

  // Final slice's MSB is the sum sign bit, taken before it lands in sum_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == RUN && last) begin
      ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[DIGIT-1] != a_q[WIDTH-1]);
    end
  end

  assign overflow = ovf_q;
`endif

  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb/tb_serial_chunk_adder.sv - self-checking bench for serial_chunk_adder (WIDTH=32, DIGIT=8)
// Overflow checks are included when SCA_OVERFLOW_EN is defined.
module tb_serial_chunk_adder;

  localparam int WIDTH = 32;
  localparam int DIGIT = 8;
  localparam int N     = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1, in2;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef SCA_OVERFLOW_EN
  logic             overflow;
`endif

  int checks = 0;
  int errors = 0;

  serial_chunk_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out)
`ifdef SCA_OVERFLOW_EN
    , .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition, carry-out is bit WIDTH of the wide sum.
  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic c);
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
  endfunction

  function automatic logic ref_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // Waits for out_valid; returns edges elapsed after the accept edge.
  task automatic wait_result(output int k);
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input int hold);
    logic [WIDTH:0] exp;
    int k;
    exp = ref_add(a, b, c);
    check({tag, ".in_ready"}, 64'(in_ready), 64'(1));
    in_valid  = 1'b1;
    in1       = a;
    in2       = b;
    c_in      = c;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    in1      = $urandom;
    in2      = $urandom;
    c_in     = 1'($urandom);
    check({tag, ".busy"}, 64'(in_ready), 64'(0));
    wait_result(k);
    check({tag, ".latency"}, 64'(k), 64'(N));
    check({tag, ".sum"}, 64'(sum), 64'(exp[WIDTH-1:0]));
    check({tag, ".c_out"}, 64'(c_out), 64'(exp[WIDTH]));
`ifdef SCA_OVERFLOW_EN
    check({tag, ".overflow"}, 64'(overflow), 64'(ref_ovf(a, b, exp[WIDTH-1:0])));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, 64'(out_valid), 64'(1));
      check({tag, ".hold_sum"}, 64'(sum), 64'(exp[WIDTH-1:0]));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, ".valid_drop"}, 64'(out_valid), 64'(0));
    check({tag, ".ready_back"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    logic [WIDTH:0] exp_bp, exp_new;
    logic [WIDTH-1:0] ra, rb;
    int k;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in1       = '0;
    in2       = '0;
    c_in      = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.sum", 64'(sum), 64'(0));
    check("reset.c_out", 64'(c_out), 64'(0));
    check("reset.out_valid", 64'(out_valid), 64'(0));
    check("reset.in_ready", 64'(in_ready), 64'(1));
`ifdef SCA_OVERFLOW_EN
    check("reset.overflow", 64'(overflow), 64'(0));
`endif
    rst_n = 1'b1;
    @(negedge clk);

    run_op("t1", 32'd12345678, 32'd98765432, 1'b0, 0);
    check("t1.value", 64'(sum), 64'(111111110));
    run_op("t2", 32'd12345678, 32'd98765432, 1'b1, 0);
    run_op("t3a", 32'd4294967290, 32'd5, 1'b0, 0);
    run_op("t3b", 32'd4294967290, 32'd6, 1'b0, 0);
    run_op("t3c", 32'd4294967290, 32'd6, 1'b1, 0);
    run_op("t6a", 32'h7FFF_FFFF, 32'd1, 1'b0, 0);
    run_op("t6b", 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    run_op("t6c", 32'h8000_0000, 32'h8000_0000, 1'b0, 2);

    // Backpressure with pending operands offered throughout DONE.
    exp_bp = ref_add(32'd1000, 32'd2000, 1'b1);
    exp_new = ref_add(32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    in_valid = 1'b1; in1 = 32'd1000; in2 = 32'd2000; c_in = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in1 = 32'hDEAD_BEEF; in2 = 32'h1234_5678; c_in = 1'b0;
    wait_result(k);
    check("bp.latency", 64'(k), 64'(N));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp.sum", 64'(sum), 64'(exp_bp[WIDTH-1:0]));
      check("bp.c_out", 64'(c_out), 64'(exp_bp[WIDTH]));
      check("bp.in_ready", 64'(in_ready), 64'(0));
      check("bp.out_valid", 64'(out_valid), 64'(1));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.ready_back", 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    check("bp.accepted", 64'(in_ready), 64'(0));
    wait_result(k);
    check("bp.new_latency", 64'(k), 64'(N));
    check("bp.new_sum", 64'(sum), 64'(exp_new[WIDTH-1:0]));
    check("bp.new_c_out", 64'(c_out), 64'(exp_new[WIDTH]));
    @(negedge clk);

    // Reset two cycles into RUN.
    in_valid = 1'b1; in1 = 32'hFFFF_0000; in2 = 32'h0001_FFFF; c_in = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst.sum", 64'(sum), 64'(0));
    check("rst.c_out", 64'(c_out), 64'(0));
    check("rst.out_valid", 64'(out_valid), 64'(0));
    check("rst.in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("rst.after", 32'd1, 32'd1, 1'b0, 0);
    check("rst.after_value", 64'(sum), 64'(2));

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op("rand", ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
